// File: rtl/int_pkg.sv
// Shared types and widths for the interrupt controller.
package int_pkg;

    localparam int VEC_W = 10;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// One IRQ line: two-flop synchroniser, history flop and a registered rise pulse.
module irq_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    output logic rise_o
);

    logic sync0_q;
    logic sync1_q;
    logic hist_q;
    logic rise_q;
    logic rise_d;

    // A level held high yields a single pulse; the line must fall before it can fire again.
    assign rise_d = sync1_q & ~hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync0_q <= irq_i;
            sync1_q <= sync0_q;
            hist_q  <= sync1_q;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: pending latch, fixed-priority select and REQ/ACK/RETI handshake.
// Handshake: INT_REQ holds with a frozen vector until INT_ACK; ACK wins over an INT_EN drop.
module int_controller
    import int_pkg::*;
#(
    parameter int               N_SRC    = 4,
    parameter logic [VEC_W-1:0] VEC_BASE = 10'h3F0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic             INT_EN,
    input  logic             INT_ACK,
    input  logic             RETI,
    output logic             INT_REQ,
    output logic [VEC_W-1:0] INT_VEC,
    output logic [ID_W-1:0]  INT_ID,
    output logic             I_CLR_OUT,
    output logic [N_SRC-1:0] PENDING,
    output logic             IN_SERVICE,
    output logic [1:0]       DBG_STATE
);

    int_state_t       state_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] clr_mask;
    logic [ID_W-1:0]  sel_d;
    logic [VEC_W-1:0] vec_d;
    logic             req_q;
    logic [VEC_W-1:0] vec_q;
    logic [ID_W-1:0]  id_q;
    logic             clr_q;
    logic             svc_q;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk_i  (CLK),
            .rst_i  (RST),
            .irq_i  (IRQ_IN[g]),
            .rise_o (rise[g])
        );
    end

    // Scan from the top so the lowest pending index is the one left standing.
    always_comb begin
        sel_d = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_d = ID_W'(i);
            end
        end
    end

    assign vec_d = VEC_BASE + VEC_W'(sel_d);

    always_comb begin
        clr_mask = '0;
        if (state_q == ST_REQ && INT_ACK) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (id_q == ID_W'(i)) begin
                    clr_mask[i] = 1'b1;
                end
            end
        end
    end

    // A fresh rise on the bit being accepted survives the clear.
    assign pend_d = (pend_q & ~clr_mask) | rise;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            vec_q   <= '0;
            id_q    <= '0;
            clr_q   <= 1'b0;
            svc_q   <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (INT_EN && (|pend_q)) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        id_q    <= sel_d;
                        vec_q   <= vec_d;
                    end
                end
                ST_REQ: begin
                    if (INT_ACK) begin
                        state_q <= ST_SERVICE;
                        req_q   <= 1'b0;
                        clr_q   <= 1'b1;
                        svc_q   <= 1'b1;
                    end else if (!INT_EN) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (RETI) begin
                        state_q <= ST_IDLE;
                        svc_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    svc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign INT_REQ    = req_q;
    assign INT_VEC    = vec_q;
    assign INT_ID     = id_q;
    assign I_CLR_OUT  = clr_q;
    assign PENDING    = pend_q;
    assign IN_SERVICE = svc_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed spot checks plus randomized traffic against a reference model.
module tb_int_controller;

    localparam logic [9:0] VEC_BASE = 10'h3F0;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] IRQ_IN = 4'h0;
    logic       INT_EN = 1'b0;
    logic       INT_ACK = 1'b0;
    logic       RETI = 1'b0;
    logic       INT_REQ;
    logic [9:0] INT_VEC;
    logic [2:0] INT_ID;
    logic       I_CLR_OUT;
    logic [3:0] PENDING;
    logic       IN_SERVICE;
    logic [1:0] DBG_STATE;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = waiting, 1 = requesting, 2 = in ISR.
    int         m_mode = 0;
    logic [3:0] m_pend = '0;
    logic       m_req = 1'b0;
    logic [9:0] m_vec = '0;
    int         m_id = 0;
    logic       m_clr = 1'b0;
    logic       m_svc = 1'b0;
    logic [3:0] samp [5];

    int_controller #(.N_SRC(4), .VEC_BASE(VEC_BASE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IRQ_IN     (IRQ_IN),
        .INT_EN     (INT_EN),
        .INT_ACK    (INT_ACK),
        .RETI       (RETI),
        .INT_REQ    (INT_REQ),
        .INT_VEC    (INT_VEC),
        .INT_ID     (INT_ID),
        .I_CLR_OUT  (I_CLR_OUT),
        .PENDING    (PENDING),
        .IN_SERVICE (IN_SERVICE),
        .DBG_STATE  (DBG_STATE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Edge k sets PENDING from IRQ_IN sampled at edges k-3 (high) and k-4 (low).
    task automatic model_step();
        logic [3:0] rise;
        logic [3:0] clrm;
        if (RST) begin
            m_mode = 0; m_pend = '0; m_req = 1'b0; m_vec = '0;
            m_id = 0; m_clr = 1'b0; m_svc = 1'b0;
            for (int k = 0; k < 5; k++) samp[k] = '0;
        end else begin
            for (int k = 4; k > 0; k--) samp[k] = samp[k-1];
            samp[0] = IRQ_IN;
            rise = samp[3] & ~samp[4];
            clrm = '0;
            m_clr = 1'b0;
            if (m_mode == 0) begin
                if (INT_EN && m_pend != 0) begin
                    m_id = lowest(m_pend);
                    m_vec = VEC_BASE + 10'(m_id);
                    m_req = 1'b1;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (INT_ACK) begin
                    clrm = 4'(1 << m_id);
                    m_clr = 1'b1;
                    m_svc = 1'b1;
                    m_req = 1'b0;
                    m_mode = 2;
                end else if (!INT_EN) begin
                    m_req = 1'b0;
                    m_mode = 0;
                end
            end else begin
                if (RETI) begin
                    m_svc = 1'b0;
                    m_mode = 0;
                end
            end
            m_pend = (m_pend & ~clrm) | rise;
        end
    endtask

    task automatic compare_all();
        check("int_req", 32'(INT_REQ), 32'(m_req));
        check("int_vec", 32'(INT_VEC), 32'(m_vec));
        check("int_id", 32'(INT_ID), 32'(m_id));
        check("i_clr_out", 32'(I_CLR_OUT), 32'(m_clr));
        check("pending", 32'(PENDING), 32'(m_pend));
        check("in_service", 32'(IN_SERVICE), 32'(m_svc));
        check("state", 32'(DBG_STATE), 32'(m_mode));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    initial begin
        for (int k = 0; k < 5; k++) samp[k] = '0;

        // Reset with all lines high, then pending appears once the pipeline fills.
        RST = 1'b1; IRQ_IN = 4'hF;
        repeat (3) tick();
        check("rst_pending", 32'(PENDING), 32'h0);
        check("rst_req", 32'(INT_REQ), 32'h0);
        RST = 1'b0;
        repeat (3) tick();
        check("pend_not_yet", 32'(PENDING), 32'h0);
        tick();
        check("pend_all", 32'(PENDING), 32'hF);

        RST = 1'b1; IRQ_IN = 4'h0;
        repeat (2) tick();
        RST = 1'b0; INT_EN = 1'b1;
        repeat (2) tick();

        // Single source 2: request on the fifth edge after the rise.
        IRQ_IN = 4'b0100;
        repeat (4) tick();
        check("single_req_early", 32'(INT_REQ), 32'h0);
        tick();
        check("single_req", 32'(INT_REQ), 32'h1);
        check("single_vec", 32'(INT_VEC), 32'h3F2);
        check("single_id", 32'(INT_ID), 32'h2);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check("ack_clr", 32'(I_CLR_OUT), 32'h1);
        check("ack_pend2", 32'(PENDING[2]), 32'h0);
        check("ack_svc", 32'(IN_SERVICE), 32'h1);
        tick();
        check("clr_pulse_end", 32'(I_CLR_OUT), 32'h0);
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
        check("reti_svc", 32'(IN_SERVICE), 32'h0);
        IRQ_IN = 4'h0;
        repeat (3) tick();

        // Randomized traffic, every output compared against the model each cycle.
        for (int c = 0; c < 1500; c++) begin
            RST = ($urandom_range(0, 149) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) IRQ_IN[b] = ~IRQ_IN[b];
            end
            INT_EN  = ($urandom_range(0, 7) != 0);
            INT_ACK = ($urandom_range(0, 2) == 0);
            RETI    = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
